control_queue: RTL and testbench
================================

CONTROL_QUEUE -- requirements
Module: control_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DEPTH, 16: FIFO entries; power of two, >= 2.
  REPEAT_EN, 1: enables button auto-repeat.
  REPEAT_DELAY, 25_000_000: clocks from press to first repeat; >= 2.
  REPEAT_PERIOD, 5_000_000: clocks between subsequent repeats; >= 2.
  DROP_CNT_W, 8: width of the drop counter.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock; one clock; all logic on posedge clk.
  rst  in  1  reset, synchronous, active-high.
  rx_valid  in  1  one-cycle strobe; rx_byte is valid.
  rx_byte  in  8  received UART byte.
  btn  in  4  debounced button levels.
  ready  in  1  consumer pops the head entry.
  flush  in  1  discard all queued and pending commands.
  control  out  control_type  head command; NONE when empty.
  valid  out  1  FIFO non-empty.
  count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
  full  out  1  count == DEPTH.
  drop_cnt  out  DROP_CNT_W  events lost to pending-slot collision; saturating.

Function
REQ-003 The UART map SHALL be case-insensitive: A->LEFT, D->RIGHT, W->DOWN, S->DROP, C->HOLD, X->ROTATE, Z->ROTATE_REV; every other byte SHALL be ignored without counting as a drop.
REQ-004 The button map SHALL be: btn[0]->RIGHT, btn[1]->HOLD, btn[2]->ROTATE, btn[3]->LEFT.
REQ-005 A button event SHALL be a rising edge, btn[i]=1 with registered prev[i]=0; prev SHALL reset to 0.
REQ-006 With REPEAT_EN=1 and btn[i] held continuously:
  - one extra event exactly REPEAT_DELAY clocks after the edge event;
  - then one extra event every REPEAT_PERIOD clocks.
  Release SHALL clear the per-button repeat counter. With REPEAT_EN=0, no repeat events SHALL occur.
REQ-007 Each of the 5 sources (0=UART, 1..4=btn[0..3]) SHALL own a one-deep pending slot (flag plus code). An event sampled at edge k SHALL set the slot at edge k.
REQ-008 An event arriving while its slot is already pending and not being granted in that cycle SHALL be discarded, and drop_cnt SHALL increment, saturating at all-ones.
REQ-009 Arbitration SHALL grant each cycle the lowest-index pending source, provided the FIFO is not full or a pop occurs in the same cycle.
  - Grant pushes the slot code at the tail and clears the slot.
  - If a new event for the granted slot arrives in that cycle, it SHALL reload the slot; no drop.
REQ-010 Latency: an event sampled at edge k into an empty, uncontended queue SHALL be pushed at edge k+1, making valid=1 and control equal to that command after edge k+1.
REQ-011 Pop SHALL occur at an edge where ready=1 and valid=1; ready while empty SHALL be ignored.
REQ-012 A simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-013 Full without pop: pending slots SHALL hold (backpressure, not drop); only REQ-008 collisions are lost.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL equal grant order.
REQ-015 flush=1 at an edge SHALL empty the FIFO, clear all pending slots and repeat counters, and discard events sampled in that cycle. drop_cnt and prev SHALL be retained. flush SHALL take priority over push and pop.
REQ-016 control SHALL be NONE whenever valid=0.

Reset
REQ-017 rst=1 at an edge SHALL set: count=0, valid=0, full=0, control=NONE, drop_cnt=0, all pending slots clear, prev=0, repeat counters 0, pointers 0.
REQ-018 rst SHALL override flush, ready and all events. Reset mid-operation SHALL lose all queued content. A button held through reset release SHALL produce one edge event.

Verification
REQ-019 rx_valid with "a", then "X" on the next cycle, then ready pulses -> control LEFT then ROTATE; count sequence 1,2,1,0.
REQ-020 rx_valid "d" plus btn[2] and btn[3] rising in the same cycle -> FIFO order RIGHT, ROTATE, LEFT on consecutive edges; drop_cnt=0.
REQ-021 DEPTH=4: fill 4 entries, keep ready=0, press btn[1] twice (separate edges) -> full=1, count=4, first press pending, drop_cnt=1; one pop -> HOLD enters, count=4.
REQ-022 REPEAT_DELAY=10, REPEAT_PERIOD=4, btn[0] held 22 clocks -> RIGHT events at offsets 0, 10, 14, 18; release -> no further events.
REQ-023 3 entries queued plus 1 pending, flush=1 with rx "s" in the same cycle -> count=0, valid=0, control=NONE next cycle, no DROP enqueued, drop_cnt unchanged.
REQ-024 rst asserted with 5 entries queued and btn[3] held -> all outputs at reset values; after release, exactly one LEFT enqueued.

Source files
------------

// File: rtl/control_queue.sv
// rtl/control_queue.sv - Command FIFO merging UART keys and button presses with auto-repeat
package control_queue_pkg;
  typedef enum logic [2:0] {
    NONE, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV
  } control_type;
endpackage

module control_queue
  import control_queue_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic [3:0]              btn,
  input  logic                    ready,
  input  logic                    flush,
  output control_type             control,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);
  localparam int AW   = $clog2(DEPTH);
  localparam int NSRC = 5;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(RMAX);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  control_type           mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [NSRC-1:0]       pend_q, pend_d;
  control_type           code_q [NSRC];
  control_type           code_d [NSRC];
  logic [3:0]            prev_q, act_q, act_d;
  logic [CW-1:0]         rep_q [4];
  logic [CW-1:0]         rep_d [4];
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  control_type           uart_code, gnt_code;
  control_type           ev_code [NSRC];
  logic [NSRC-1:0]       ev, gnt;
  logic [3:0]            btn_ev;
  logic                  pop, push, can_push, found;
  logic [2:0]            ndrop;
  logic [DROP_CNT_W:0]   drop_sum;

  always_comb begin
    uart_code = NONE;
    case (rx_byte)
      "A", "a": uart_code = LEFT;
      "D", "d": uart_code = RIGHT;
      "W", "w": uart_code = DOWN;
      "S", "s": uart_code = DROP;
      "C", "c": uart_code = HOLD;
      "X", "x": uart_code = ROTATE;
      "Z", "z": uart_code = ROTATE_REV;
      default:  uart_code = NONE;
    endcase
  end

  // Repeat counters count down from the edge; act_q gates repeats so a button
  // still held after flush stays silent until it is released and pressed again.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      act_d[i]  = act_q[i];
      rep_d[i]  = rep_q[i];
      btn_ev[i] = 1'b0;
      if (!btn[i]) begin
        act_d[i] = 1'b0;
        rep_d[i] = '0;
      end else if (!prev_q[i]) begin
        btn_ev[i] = 1'b1;
        act_d[i]  = REPEAT_EN;
        rep_d[i]  = CW'(REPEAT_DELAY - 1);
      end else if (act_q[i]) begin
        if (rep_q[i] == '0) begin
          btn_ev[i] = 1'b1;
          rep_d[i]  = CW'(REPEAT_PERIOD - 1);
        end else begin
          rep_d[i] = rep_q[i] - CW'(1);
        end
      end
    end
  end

  assign ev         = {btn_ev, rx_valid && (uart_code != NONE)};
  assign ev_code[0] = uart_code;
  assign ev_code[1] = RIGHT;
  assign ev_code[2] = HOLD;
  assign ev_code[3] = ROTATE;
  assign ev_code[4] = LEFT;

  assign valid    = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign drop_cnt = drop_q;
  assign control  = valid ? mem_q[rd_ptr_q] : NONE;
  assign pop      = ready && valid;
  assign can_push = !full || pop;
  assign push     = |gnt;

  always_comb begin
    gnt      = '0;
    gnt_code = NONE;
    found    = 1'b0;
    pend_d   = pend_q;
    ndrop    = '0;
    for (int s = 0; s < NSRC; s++) begin
      code_d[s] = code_q[s];
      if (pend_q[s] && !found && can_push) begin
        gnt[s]   = 1'b1;
        gnt_code = code_q[s];
        found    = 1'b1;
      end
      if (gnt[s]) begin
        pend_d[s] = ev[s];
        if (ev[s]) code_d[s] = ev_code[s];
      end else if (ev[s]) begin
        if (pend_q[s]) begin
          ndrop = ndrop + 3'd1;
        end else begin
          pend_d[s] = 1'b1;
          code_d[s] = ev_code[s];
        end
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + (DROP_CNT_W+1)'(ndrop);
    drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      act_q    <= '0;
      for (int s = 0; s < NSRC; s++) code_q[s] <= NONE;
      for (int i = 0; i < 4; i++) rep_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
      for (int s = 0; s < NSRC; s++) code_q[s] <= code_d[s];
      for (int i = 0; i < 4; i++) rep_q[i] <= rep_d[i];
    end
    if (rst) begin
      prev_q <= '0;
      drop_q <= '0;
    end else begin
      prev_q <= btn;
      if (!flush) drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[wr_ptr_q] <= gnt_code;
  end
endmodule

// File: tb/tb_control_queue.sv
// tb/tb_control_queue.sv - Directed self-checking bench for control_queue
module tb_control_queue;
  import control_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rx_valid, ready, flush;
  logic [7:0]  rx_byte;
  logic [3:0]  btn;
  control_type ctl_a, ctl_b;
  logic        valid_a, valid_b, full_a, full_b;
  logic [3:0]  count_a;
  logic [2:0]  count_b;
  logic [7:0]  drop_a, drop_b;
  int          n_checks = 0;
  int          n_err = 0;
  int          prev_cnt;
  logic [31:0] push_mask;
  control_type exp_seq [4];

  always #5 clk = ~clk;

  control_queue #(.DEPTH(8), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .DROP_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .btn(btn),
    .ready(ready), .flush(flush), .control(ctl_a), .valid(valid_a),
    .count(count_a), .full(full_a), .drop_cnt(drop_a)
  );

  control_queue #(.DEPTH(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .DROP_CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .btn(btn),
    .ready(ready), .flush(flush), .control(ctl_b), .valid(valid_b),
    .count(count_b), .full(full_b), .drop_cnt(drop_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; btn = 4'h0; ready = 1'b0; flush = 1'b0;
    do_reset();
    check("rst_count", int'(count_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_full", int'(full_a), 0);
    check("rst_control", int'(ctl_a), int'(NONE));
    check("rst_drop", int'(drop_a), 0);

    // UART lower/upper case, FIFO order and count progression
    rx_valid = 1'b1; rx_byte = "a"; tick();
    rx_byte = "X"; tick();
    check("uart_cnt1", int'(count_a), 1);
    check("uart_head_left", int'(ctl_a), int'(LEFT));
    rx_valid = 1'b0; tick();
    check("uart_cnt2", int'(count_a), 2);
    ready = 1'b1; tick();
    check("uart_cnt3", int'(count_a), 1);
    check("uart_head_rot", int'(ctl_a), int'(ROTATE));
    tick();
    check("uart_cnt4", int'(count_a), 0);
    check("uart_empty_ctl", int'(ctl_a), int'(NONE));
    ready = 1'b0;

    // Same-cycle UART and two buttons: arbitration by source index
    rx_valid = 1'b1; rx_byte = "d"; btn = 4'b1100; tick();
    rx_valid = 1'b0; btn = 4'b0000; tick();
    check("arb_first_cnt", int'(count_a), 1);
    check("arb_first", int'(ctl_a), int'(RIGHT));
    tick();
    check("arb_second_cnt", int'(count_a), 2);
    tick();
    check("arb_third_cnt", int'(count_a), 3);
    ready = 1'b1; tick();
    check("arb_pop1", int'(ctl_a), int'(ROTATE));
    tick();
    check("arb_pop2", int'(ctl_a), int'(LEFT));
    tick();
    check("arb_pop3", int'(ctl_a), int'(NONE));
    ready = 1'b0;
    check("arb_drop", int'(drop_a), 0);

    // Full FIFO on DEPTH=4: backpressure, collision drop, push with pop when full
    do_reset();
    rx_valid = 1'b1; rx_byte = "a"; tick();
    rx_byte = "d"; tick();
    rx_byte = "W"; tick();
    rx_byte = "s"; tick();
    rx_valid = 1'b0; tick();
    check("full_cnt", int'(count_b), 4);
    check("full_flag", int'(full_b), 1);
    btn = 4'b0010; tick();
    btn = 4'b0000; tick();
    btn = 4'b0010; tick();
    btn = 4'b0000; tick();
    check("full_hold_cnt", int'(count_b), 4);
    check("full_drop", int'(drop_b), 1);
    check("full_head", int'(ctl_b), int'(LEFT));
    ready = 1'b1; tick();
    check("full_pushpop_cnt", int'(count_b), 4);
    check("full_pushpop_head", int'(ctl_b), int'(RIGHT));
    exp_seq = '{DOWN, DROP, HOLD, NONE};
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("full_drain%0d", i), int'(ctl_b), int'(exp_seq[i]));
    end
    ready = 1'b0;
    check("full_drain_drop", int'(drop_b), 1);

    // Auto-repeat: held 22 clocks, events at 0,10,14,18, pushed one edge later
    do_reset();
    push_mask = '0;
    prev_cnt = int'(count_a);
    btn = 4'b0001;
    for (int j = 0; j < 32; j++) begin
      if (j == 22) btn = 4'b0000;
      tick();
      if (int'(count_a) > prev_cnt) push_mask[j] = 1'b1;
      prev_cnt = int'(count_a);
    end
    check("rep_push_mask", int'(push_mask), 32'h0008_8802);
    check("rep_total", int'(count_a), 4);
    check("rep_disabled_cnt", int'(count_b), 1);

    // Flush with entries queued, a slot pending and a same-cycle UART event
    do_reset();
    rx_valid = 1'b1; rx_byte = "a"; tick();
    rx_byte = "d"; tick();
    rx_byte = "w"; tick();
    rx_valid = 1'b0; btn = 4'b0010; tick();
    check("flush_pre_cnt", int'(count_a), 3);
    flush = 1'b1; rx_valid = 1'b1; rx_byte = "s"; btn = 4'b0000; tick();
    flush = 1'b0; rx_valid = 1'b0;
    check("flush_cnt", int'(count_a), 0);
    check("flush_valid", int'(valid_a), 0);
    check("flush_ctl", int'(ctl_a), int'(NONE));
    tick();
    tick();
    check("flush_no_late_push", int'(count_a), 0);
    check("flush_drop", int'(drop_a), 0);

    // Reset mid-operation with a button held through release
    do_reset();
    rx_valid = 1'b1; rx_byte = "a"; tick();
    rx_byte = "d"; tick();
    rx_byte = "w"; tick();
    rx_byte = "s"; tick();
    rx_byte = "c"; tick();
    rx_valid = 1'b0; tick();
    check("rst2_pre_cnt", int'(count_a), 5);
    btn = 4'b1000;
    rst = 1'b1; tick(); tick();
    check("rst2_count", int'(count_a), 0);
    check("rst2_valid", int'(valid_a), 0);
    check("rst2_full", int'(full_a), 0);
    check("rst2_ctl", int'(ctl_a), int'(NONE));
    check("rst2_drop", int'(drop_a), 0);
    rst = 1'b0; tick(); tick();
    check("rst2_left_cnt", int'(count_a), 1);
    check("rst2_left", int'(ctl_a), int'(LEFT));
    btn = 4'b0000; tick(); tick();
    check("rst2_single", int'(count_a), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
